// File: rtl/fir_capture_pkg.sv
// fir_capture_pkg: shared state encoding and sample geometry for the capture path.
package fir_capture_pkg;
  localparam int SAMPLE_WIDTH     = 16;
  localparam int BYTES_PER_SAMPLE = 2;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_LSB = 3'd1,
    WAIT_MSB = 3'd2,
    WRITE    = 3'd3,
    DONE     = 3'd4
  } state_e;
endpackage

// File: rtl/capture_timeout.sv
// capture_timeout: clear/enable up-counter flagging when it sits at LIMIT-1.
module capture_timeout #(
  parameter int LIMIT = 25000
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  localparam int W = $clog2(LIMIT);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = i_clr ? '0 : i_en ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign o_tc = cnt_q == W'(LIMIT - 1);
endmodule

// File: rtl/uart_sample_capture.sv
// uart_sample_capture: packs UART byte pairs (LSB first) into 16-bit samples written to BRAM.
// Define SAMPLE_CAPTURE_TIMEOUT_EN to discard a half sample whose MSB never arrives.
module uart_sample_capture
  import fir_capture_pkg::*;
#(
  parameter int DEPTH        = 256,
  parameter int ADDR_WIDTH   = 8,
  parameter int TIMEOUT_CLKS = 25000
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_start,
  input  logic                    i_rxdatval,
  input  logic [7:0]              i_rxbyte,
  output logic                    o_wen,
  output logic [ADDR_WIDTH-1:0]   o_waddr,
  output logic [SAMPLE_WIDTH-1:0] o_wdata,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_timeout_err
);
  if ((64'd1 << ADDR_WIDTH) < 64'(DEPTH) || TIMEOUT_CLKS < 2) begin : g_bad_params
    $error("uart_sample_capture: ADDR_WIDTH too small for DEPTH or TIMEOUT_CLKS < 2");
  end
  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d, waddr_q, waddr_d;
  logic [7:0]              lsb_q, lsb_d;
  logic [SAMPLE_WIDTH-1:0] wdata_q, wdata_d;
  logic                    wen_q, wen_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                    tmo_tc;
`ifdef SAMPLE_CAPTURE_TIMEOUT_EN
  capture_timeout #(.LIMIT(TIMEOUT_CLKS)) u_timeout (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_clr  (state_q == WAIT_LSB && i_rxdatval),
    .i_en   (state_q == WAIT_MSB && !i_rxdatval),
    .o_tc   (tmo_tc)
  );
`else
  assign tmo_tc = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lsb_d   = lsb_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (i_start) begin
        addr_d  = '0;
        state_d = WAIT_LSB;
      end
      WAIT_LSB: if (i_rxdatval) begin
        lsb_d   = i_rxbyte;
        state_d = WAIT_MSB;
      end
      WAIT_MSB: if (i_rxdatval) begin
        wdata_d = {i_rxbyte, lsb_q};
        waddr_d = addr_q;
        state_d = WRITE;
      end else if (tmo_tc) begin
        err_d   = 1'b1;
        state_d = WAIT_LSB;
      end
      WRITE: begin
        state_d = addr_q == ADDR_WIDTH'(DEPTH - 1) ? DONE : WAIT_LSB;
        addr_d  = addr_q == ADDR_WIDTH'(DEPTH - 1) ? addr_q : addr_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    wen_d  = state_d == WRITE;
    done_d = state_d == DONE;
    busy_d = state_d == WAIT_LSB || state_d == WAIT_MSB || state_d == WRITE;
  end
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      lsb_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lsb_q   <= lsb_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  assign o_wen         = wen_q;
  assign o_waddr       = waddr_q;
  assign o_wdata       = wdata_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_timeout_err = err_q;
endmodule

// File: tb/tb_uart_sample_capture.sv
// tb_uart_sample_capture: table vectors, directed corner cases and random traffic
// checked every cycle against a transaction-level model of the capture rules.
module tb_uart_sample_capture;
  localparam int DEPTH = 4, AW = 2, TMO_CLKS = 100;
`ifdef SAMPLE_CAPTURE_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif
  logic clk = 1'b0, rstn = 1'b1, start = 1'b0, dv = 1'b0;
  logic [7:0] rxb = '0;
  logic wen, busy, done, terr;
  logic [AW-1:0] waddr;
  logic [15:0] wdata;
  int vectors = 0, miscompares = 0;
  uart_sample_capture #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .TIMEOUT_CLKS(TMO_CLKS)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_rxdatval(dv), .i_rxbyte(rxb),
    .o_wen(wen), .o_waddr(waddr), .o_wdata(wdata), .o_busy(busy), .o_done(done),
    .o_timeout_err(terr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference model: capture is a session of DEPTH byte pairs; the cycle showing a
  // write, and the cycle announcing completion, swallow whatever arrives.
  bit m_busy, m_half, m_wr, m_fin;
  logic [7:0] m_lsb;
  int m_idx, m_gap;
  logic e_wen, e_done, e_err;
  logic [AW-1:0] e_waddr;
  logic [15:0] e_wdata;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_busy = 0; m_half = 0; m_wr = 0; m_fin = 0; m_lsb = 0; m_idx = 0; m_gap = 0;
      e_wen = 0; e_done = 0; e_err = 0; e_waddr = 0; e_wdata = 0;
    end else begin
      e_wen = 0; e_done = 0; e_err = 0;
      if (m_fin) m_busy = 0;
      else if (m_wr) begin
        if (m_idx == DEPTH) begin e_done = 1; m_busy = 0; end
      end else if (!m_busy) begin
        if (start) begin m_busy = 1; m_idx = 0; m_half = 0; end
      end else if (dv) begin
        if (!m_half) begin m_half = 1; m_lsb = rxb; m_gap = 0; end
        else begin
          e_wen = 1; e_waddr = AW'(m_idx); e_wdata = {rxb, m_lsb}; m_idx++; m_half = 0;
        end
      end else if (m_half && TMO) begin
        if (m_gap == TMO_CLKS - 1) begin e_err = 1; m_half = 0; end
        else m_gap++;
      end
      m_wr = e_wen; m_fin = e_done;
    end
  end
  typedef struct {logic [AW-1:0] a; logic [15:0] d; int cyc;} wr_t;
  wr_t wq[$];
  int cyc = 0, done_n = 0, err_n = 0, done_cyc = -1;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    chk("cycle_model", {wen, done, busy, terr, waddr, wdata},
        {e_wen, e_done, m_busy, e_err, e_waddr, e_wdata});
    if (wen) wq.push_back('{waddr, wdata, cyc});
    if (done) begin done_n++; done_cyc = cyc; end
    if (terr) err_n++;
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b, input int gap);
    dv = 1; rxb = b;
    tick(1);
    dv = 0; rxb = 8'($urandom);
    tick(gap - 1);
  endtask
  task automatic pulse_start();
    start = 1; tick(1); start = 0;
  endtask
  task automatic clear_log();
    wq.delete(); done_n = 0; err_n = 0; done_cyc = -1;
  endtask
  task automatic chk_wr(input string nm, input int i, input logic [AW-1:0] a, input logic [15:0] d);
    if (wq.size() <= i) chk({nm, "_missing"}, 64'(wq.size()), 64'(i + 1));
    else chk(nm, {wq[i].a, wq[i].d}, {a, d});
  endtask
  typedef struct {logic [7:0] lsb, msb; logic [AW-1:0] addr; logic [15:0] data;} vec_t;
  vec_t tbl[DEPTH];
  initial begin
    tbl[0] = '{8'h34, 8'h12, 2'd0, 16'h1234};
    tbl[1] = '{8'hCD, 8'hAB, 2'd1, 16'hABCD};
    tbl[2] = '{8'h01, 8'h00, 2'd2, 16'h0001};
    tbl[3] = '{8'hFF, 8'hFF, 2'd3, 16'hFFFF};
    #1 rstn = 0;
    tick(3);
    rstn = 1;
    tick(1);
    chk("reset_outputs", {wen, done, busy, terr, waddr, wdata}, '0);
    tick(40);
    chk("idle_busy", busy, 0);
    chk("idle_no_write", wq.size(), 0);
    clear_log();
    pulse_start();
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < DEPTH; i++) begin
      send(tbl[i].lsb, 20);
      send(tbl[i].msb, 20);
    end
    for (int i = 0; i < DEPTH; i++) chk_wr("table_write", i, tbl[i].addr, tbl[i].data);
    chk("table_done_count", done_n, 1);
    if (wq.size() == DEPTH) chk("done_after_last_write", done_cyc, wq[DEPTH-1].cyc + 1);
    chk("busy_after_done", busy, 0);
    clear_log();
    send(8'h55, 10);
    chk("idle_byte_no_write", wq.size(), 0);
    chk("idle_byte_busy", busy, 0);
    clear_log();
    pulse_start();
    send(8'h34, 150);
    send(8'h78, 20);
    send(8'h56, 20);
    chk_wr("timeout_first", 0, 2'd0, TMO ? 16'h5678 : 16'h7834);
    chk("timeout_err_count", err_n, TMO ? 1 : 0);
    for (int i = 0; i < 7; i++) send(8'(i), 20);
    chk("timeout_done_count", done_n, 1);
    clear_log();
    pulse_start();
    for (int i = 0; i < 4; i++) send(8'(8'h10 + i), 20);
    pulse_start();
    for (int i = 0; i < 4; i++) send(8'(8'h20 + i), 20);
    chk_wr("restart_ignored_a2", 2, 2'd2, 16'h2120);
    chk_wr("restart_ignored_a3", 3, 2'd3, 16'h2322);
    chk("restart_write_count", wq.size(), 4);
    chk("restart_done_count", done_n, 1);
    clear_log();
    pulse_start();
    for (int i = 0; i < 5; i++) send(8'(8'h40 + i), 20);
    rstn = 0;
    #1 chk("reset_mid_capture", {wen, done, busy, terr, waddr, wdata}, '0);
    tick(2);
    rstn = 1;
    tick(2);
    chk("reset_no_done", done_n, 0);
    clear_log();
    pulse_start();
    send(8'hBE, 20);
    send(8'hEF, 20);
    chk_wr("after_reset_addr0", 0, 2'd0, 16'hEFBE);
    for (int r = 0; r < 6; r++) begin
      int p = (r % 2) ? 150 : 6;
      for (int c = 0; c < 2500; c++) begin
        dv = $urandom_range(0, p - 1) == 0;
        rxb = 8'($urandom);
        start = $urandom_range(0, 59) == 0;
        if ($urandom_range(0, 2999) == 0) rstn = 0;
        tick(1);
        rstn = 1;
      end
    end
    dv = 0; start = 0;
    tick(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_sample_capture.md
# uart_sample_capture

Downstream consumer of the UART receiver in the sample-signal BRAM path. It takes the receiver's one-cycle byte strobes and assembles byte pairs, LSB first, into 16-bit signed samples. It writes each sample into the sample BRAM at a sequential address and signals completion after DEPTH samples, so the FIR stage can start reading.

## Interface
- DEPTH, 256: number of samples per capture; BRAM depth.
- ADDR_WIDTH, 8: BRAM address width; must satisfy 2^ADDR_WIDTH ≥ DEPTH.
- TIMEOUT_CLKS, 25000: idle clocks allowed between the LSB and MSB bytes of one sample (2 byte-times at 1250 clk/bit).
- i_clk  in  1  single clock for the block.
- i_rstn  in  1  reset, asynchronous assert, active-low.
- i_start  in  1  one-cycle arm pulse; starts a capture at address 0.
- i_rxdatval  in  1  byte-valid strobe from the UART receiver; one cycle per byte.
- i_rxbyte  in  8  received byte; valid only while i_rxdatval=1.
- o_wen  out  1  BRAM write enable; one cycle per sample.
- o_waddr  out  ADDR_WIDTH  BRAM write address.
- o_wdata  out  16  sample, {MSB byte, LSB byte}.
- o_busy  out  1  high from the cycle after i_start until the cycle o_done pulses.
- o_done  out  1  one-cycle pulse after the last sample is written.
- o_timeout_err  out  1  one-cycle pulse when a half-received sample is discarded.

## Operation
- Reset values: all outputs 0; state IDLE; address counter 0; LSB holding register 0; timeout counter 0.
- States: IDLE, WAIT_LSB, WAIT_MSB, WRITE, DONE. Registered (Moore) outputs.
- IDLE:
  - o_busy=0.
  - i_start=1 → clear address to 0 and go to WAIT_LSB.
  - i_rxdatval is ignored.
- WAIT_LSB:
  - On i_rxdatval, latch i_rxbyte into the LSB register, clear the timeout counter and go to WAIT_MSB.
- WAIT_MSB:
  - On i_rxdatval, load o_wdata={i_rxbyte, LSB}, drive o_waddr=address and go to WRITE.
  - Otherwise, increment the timeout counter (see Configuration).
- WRITE:
  - o_wen=1 for exactly this cycle.
  - If address==DEPTH-1, go to DONE with the address held.
  - Otherwise, increment the address and go to WAIT_LSB.
- DONE:
  - o_done=1 for one cycle, then IDLE.
  - o_waddr and o_wdata hold their last values until the next write.
- Boundary conditions:
  - i_start while o_busy=1: ignored. No restart mid-capture.
  - i_start and i_rxdatval in the same IDLE cycle: the byte is dropped. Capture starts with the next byte.
  - i_rxdatval during WRITE or DONE: the byte is dropped. The upstream byte spacing of ≥10 bit-times makes this unreachable in-system, but the RTL must not corrupt state.
  - Address wrap: never occurs. The counter stops at DEPTH-1.
  - Reset mid-capture: immediate return to IDLE with all outputs 0. No partial o_done.
- Arithmetic: the address counter is ADDR_WIDTH bits, unsigned. The timeout counter is $clog2(TIMEOUT_CLKS) bits, saturating-free and cleared on each LSB. Samples are two's complement; no sign manipulation is done here.

## Timing
- MSB i_rxdatval at cycle N → o_wen=1 at cycle N+1, with o_waddr and o_wdata valid the same cycle.
- Last WRITE at cycle M → o_done at M+1 → o_busy falls at M+1; IDLE at M+2.
- i_start at cycle S → o_busy=1 and WAIT_LSB at S+1. The first accepted byte arrives at ≥S+1.
- Timeout: the counter reaches TIMEOUT_CLKS-1 in WAIT_MSB → o_timeout_err pulses the next cycle, state returns to WAIT_LSB, and the address is unchanged.

## Configuration
- SAMPLE_CAPTURE_TIMEOUT_EN defined: the timeout counter and resynchronisation described above are present.
- Undefined: no counter. WAIT_MSB waits indefinitely and o_timeout_err is tied to 0. All other behaviour is identical.

## Structure
- Shared package fir_capture_pkg holds:
  - the state encoding constants (3-bit: IDLE=0, WAIT_LSB=1, WAIT_MSB=2, WRITE=3, DONE=4);
  - SAMPLE_WIDTH=16;
  - BYTES_PER_SAMPLE=2.
- One sub-module, capture_timeout: clear/enable counter with a terminal-count pulse. It is instantiated only under SAMPLE_CAPTURE_TIMEOUT_EN.

## Test plan
Bench with DEPTH=4, TIMEOUT_CLKS=100.
- Reset released with no stimulus → all outputs 0, and o_busy stays 0 indefinitely.
- Pulse i_start, then bytes 0x34,0x12,0xCD,0xAB,0x01,0x00,0xFF,0xFF spaced 20 clk → writes at addr 0..3 of 0x1234, 0xABCD, 0x0001, 0xFFFF. o_wen fires one cycle after each MSB. o_done pulses once, one cycle after the addr-3 write.
- Byte 0x55 in IDLE with no i_start → no o_wen and no state change.
- After i_start, send 0x34, wait 150 clk, then send 0x78,0x56 → o_timeout_err pulses once, then 0x5678 is written at addr 0. With the macro undefined, 0x7834 is written instead and there is no error pulse.
- i_start asserted mid-capture after 2 samples → ignored. The capture completes at addr 3 without restarting.
- i_rstn asserted during WAIT_MSB at sample 2 → outputs 0 immediately. After release plus i_start, writing resumes at addr 0.
